mdu_alu: RTL and testbench

MDU_ALU -- requirements
Module: mdu_alu

---
 rtl/mdu_alu.sv | 186 ++++++++++++++++++
 tb/tb_mdu_alu.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mdu_alu.sv
// Purpose : single-issue ALU with MIPS-style HI/LO multiply/divide unit and live A/B comparator.
// Latency : ALU/MFHI/MFLO/MTHI/MTLO 1 cycle; MULT(U) MUL_CYCLES cycles busy; DIV(U) WIDTH cycles busy.
// Backpr. : start is ignored while busy=1; a new start is accepted in the cycle done pulses.
// Ports   : clk, reset (async, active-high); start/op/A/B request; cmp_signed selects flag compare mode;
//           Y registered result; done completion pulse; busy mul/div in flight; hi/lo HI/LO registers;
//           Greater/Equal/Less combinational compare of live A vs B.
module mdu_alu #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cmp_signed,
  output logic [WIDTH-1:0] Y,
  output logic             done,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             Greater,
  output logic             Equal,
  output logic             Less
);

  localparam int CNT_MAX = (WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [3:0] OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_OR   = 4'd2,  OP_LUI  = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4,  OP_AND  = 4'd5,  OP_SLT  = 4'd6,  OP_SLTU = 4'd7;
  localparam logic [3:0] OP_MULT = 4'd8,  OP_MULTU= 4'd9,  OP_DIV  = 4'd10, OP_DIVU = 4'd11;
  localparam logic [3:0] OP_MFHI = 4'd12, OP_MFLO = 4'd13, OP_MTHI = 4'd14, OP_MTLO = 4'd15;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic             mul_last, div_last;

  // multiply operands captured at start; product formed from the held copies
  logic [WIDTH-1:0]   mul_a, mul_b;
  logic               mul_signed;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod;

  // restoring divider on magnitudes; signs re-applied on the final step
  logic [WIDTH-1:0] quo, rem, dvsr;
  logic             neg_q, neg_r, div_zero;
  logic [WIDTH:0]   rem_sh, rem_sub;
  logic             ge;
  logic [WIDTH-1:0] quo_nxt, rem_nxt, q_fin, r_fin;
  logic             dvd_neg, dvs_neg;

  logic [WIDTH-1:0] alu_res;
  logic             lt_s, lt_u;

  // ---------------- comparator ----------------
  assign lt_s    = $signed(A) < $signed(B);
  assign lt_u    = A < B;
  assign Equal   = (A == B);
  assign Less    = cmp_signed ? lt_s : lt_u;
  assign Greater = !Equal && !Less;

  // ---------------- single-cycle results ----------------
  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = A + B;
      OP_SUB:  alu_res = A - B;
      OP_OR:   alu_res = A | B;
      OP_LUI:  alu_res = {B[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_XOR:  alu_res = A ^ B;
      OP_AND:  alu_res = A & B;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, lt_s};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, lt_u};
      OP_MFHI: alu_res = hi;
      OP_MFLO: alu_res = lo;
      default: alu_res = '0;
    endcase
  end

  // ---------------- multiply ----------------
  assign ext_a = mul_signed ? {{WIDTH{mul_a[WIDTH-1]}}, mul_a} : {{WIDTH{1'b0}}, mul_a};
  assign ext_b = mul_signed ? {{WIDTH{mul_b[WIDTH-1]}}, mul_b} : {{WIDTH{1'b0}}, mul_b};
  assign prod  = ext_a * ext_b;  // low 2*WIDTH bits of the extended product are exact

  // ---------------- divide step ----------------
  assign dvd_neg = (op == OP_DIV) && A[WIDTH-1];
  assign dvs_neg = (op == OP_DIV) && B[WIDTH-1];
  assign rem_sh  = {rem, quo[WIDTH-1]};
  assign rem_sub = rem_sh - {1'b0, dvsr};
  assign ge      = rem_sh >= {1'b0, dvsr};
  assign rem_nxt = ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign quo_nxt = {quo[WIDTH-2:0], ge};
  // |MIN| = MIN as unsigned, so MIN / -1 falls out as MIN with remainder 0
  assign q_fin   = div_zero ? '1 : (neg_q ? -quo_nxt : quo_nxt);
  assign r_fin   = neg_r ? -rem_nxt : rem_nxt;

  assign mul_last = (cnt == CW'(MUL_CYCLES - 1));
  assign div_last = (cnt == CW'(WIDTH - 1));

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    case (state)
      IDLE: if (start) begin
              if (op == OP_MULT || op == OP_MULTU)   state_nxt = MUL;
              else if (op == OP_DIV || op == OP_DIVU) state_nxt = DIV;
            end
      MUL:  if (mul_last) state_nxt = IDLE;
      DIV:  if (div_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Y          <= '0;
      hi         <= '0;
      lo         <= '0;
      done       <= 1'b0;
      cnt        <= '0;
      mul_a      <= '0;
      mul_b      <= '0;
      mul_signed <= 1'b0;
      quo        <= '0;
      rem        <= '0;
      dvsr       <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      div_zero   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          cnt <= '0;
          case (op)
            OP_MULT, OP_MULTU: begin
              mul_a      <= A;
              mul_b      <= B;
              mul_signed <= (op == OP_MULT);
            end
            OP_DIV, OP_DIVU: begin
              quo      <= dvd_neg ? -A : A;
              dvsr     <= dvs_neg ? -B : B;
              rem      <= '0;
              neg_q    <= dvd_neg ^ dvs_neg;
              neg_r    <= dvd_neg;
              div_zero <= (B == '0);
            end
            OP_MTHI: begin hi <= A; done <= 1'b1; end
            OP_MTLO: begin lo <= A; done <= 1'b1; end
            default: begin Y <= alu_res; done <= 1'b1; end
          endcase
        end
        MUL: begin
          cnt <= cnt + 1'b1;
          if (mul_last) begin
            {hi, lo} <= prod;
            done     <= 1'b1;
          end
        end
        DIV: begin
          cnt <= cnt + 1'b1;
          quo <= quo_nxt;
          rem <= rem_nxt;
          if (div_last) begin
            lo   <= q_fin;
            hi   <= r_fin;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_alu.sv
// Purpose : directed self-checking bench for mdu_alu (WIDTH=32, MUL_CYCLES=5).
// Latency : drives on negedge, samples on negedge, one negedge after each sampling posedge.
// Backpr. : exercises start-while-busy and start-in-done-cycle behaviour.
module tb_mdu_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] A, B;
  logic        cmp_signed;
  logic [31:0] Y, hi, lo;
  logic        done, busy, Greater, Equal, Less;

  int n_chk  = 0;
  int n_fail = 0;
  int bc;
  int n_done;

  mdu_alu #(.WIDTH(32), .MUL_CYCLES(5)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .cmp_signed(cmp_signed), .Y(Y), .done(done), .busy(busy),
    .hi(hi), .lo(lo), .Greater(Greater), .Equal(Equal), .Less(Less)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  // counts busy cycles from the current negedge; stops at the first idle negedge
  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy && cycles < 100) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic one_cycle(input string tag, input logic [3:0] o,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    do_op(o, a, b);
    chk({tag, "_y"}, Y, exp);
    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_busy"}, 32'(busy), 0);
  endtask

  task automatic long_op(input string tag, input logic [3:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int cyc,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo, input logic [31:0] exp_y);
    do_op(o, a, b);
    wait_idle(bc);
    chk({tag, "_cycles"}, 32'(bc), 32'(cyc));
    chk({tag, "_done"}, 32'(done), 1);
    chk({tag, "_hi"}, hi, exp_hi);
    chk({tag, "_lo"}, lo, exp_lo);
    chk({tag, "_y"}, Y, exp_y);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 4'd0; A = '0; B = '0; cmp_signed = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_y", Y, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    reset = 1'b0;

    // single-cycle ALU ops
    one_cycle("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'h1, 32'h0);
    @(negedge clk);
    chk("add_done_pulse", 32'(done), 0);
    one_cycle("sub", 4'd1, 32'd5, 32'd7, 32'hFFFF_FFFE);
    one_cycle("or",  4'd2, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F);
    one_cycle("lui", 4'd3, 32'h0, 32'h1234_ABCD, 32'hABCD_0000);
    one_cycle("xor", 4'd4, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF00F_F00F);
    one_cycle("and", 4'd5, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00);
    one_cycle("slt", 4'd6, 32'hFFFF_FFFF, 32'h1, 32'h1);
    one_cycle("sltu",4'd7, 32'hFFFF_FFFF, 32'h1, 32'h0);

    // multiply: Y untouched (still 0 from SLTU)
    long_op("mult", 4'd8, 32'hFFFF_FFFD, 32'd7, 5, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 32'h0);
    one_cycle("mflo", 4'd13, 32'h0, 32'h0, 32'hFFFF_FFEB);
    one_cycle("mfhi", 4'd12, 32'h0, 32'h0, 32'hFFFF_FFFF);
    long_op("multu", 4'd9, 32'hFFFF_FFFF, 32'd2, 5, 32'h1, 32'hFFFF_FFFE, 32'hFFFF_FFFF);

    // divide
    long_op("div_neg",  4'd10, 32'hFFFF_FFF9, 32'd2, 32, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    long_op("divu_z",   4'd11, 32'd7, 32'd0, 32, 32'h7, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    long_op("div_ovf",  4'd10, 32'h8000_0000, 32'hFFFF_FFFF, 32, 32'h0, 32'h8000_0000, 32'hFFFF_FFFF);
    long_op("div_negb", 4'd10, 32'd7, 32'hFFFF_FFFE, 32, 32'h1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);

    // move to HI/LO: Y stays at 0xFFFFFFFF from MFHI
    do_op(4'd14, 32'h55, 32'h0);
    chk("mthi_hi", hi, 32'h55);
    chk("mthi_done", 32'(done), 1);
    chk("mthi_y", Y, 32'hFFFF_FFFF);
    do_op(4'd15, 32'hAA, 32'h0);
    chk("mtlo_lo", lo, 32'hAA);
    chk("mtlo_hi", hi, 32'h55);

    // start while busy is ignored; start in the done cycle is taken
    do_op(4'd11, 32'd100, 32'd7);
    start = 1'b1; op = 4'd0; A = 32'd1; B = 32'd2;
    @(negedge clk);
    start = 1'b0;
    wait_idle(bc);
    chk("ign_cycles", 32'(bc), 31);
    chk("ign_done", 32'(done), 1);
    chk("ign_lo", lo, 32'd14);
    chk("ign_hi", hi, 32'd2);
    chk("ign_y", Y, 32'hFFFF_FFFF);
    start = 1'b1; op = 4'd0; A = 32'd3; B = 32'd4;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_y", Y, 32'd7);
    chk("b2b_done", 32'(done), 1);
    chk("b2b_busy", 32'(busy), 0);

    // reset in the middle of a divide
    do_op(4'd10, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    chk("rstdiv_busy_before", 32'(busy), 1);
    reset = 1'b1;
    #1;
    chk("rstdiv_busy", 32'(busy), 0);
    chk("rstdiv_hi", hi, 0);
    chk("rstdiv_lo", lo, 0);
    chk("rstdiv_y", Y, 0);
    @(negedge clk);
    reset = 1'b0;
    n_done = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("rstdiv_no_done", 32'(n_done), 0);
    chk("rstdiv_hi_after", hi, 0);
    chk("rstdiv_lo_after", lo, 0);

    // comparator
    A = 32'h8000_0000; B = 32'h1; cmp_signed = 1'b1;
    #1;
    chk("cmp_s_less", 32'(Less), 1);
    chk("cmp_s_greater", 32'(Greater), 0);
    chk("cmp_s_equal", 32'(Equal), 0);
    cmp_signed = 1'b0;
    #1;
    chk("cmp_u_greater", 32'(Greater), 1);
    chk("cmp_u_less", 32'(Less), 0);
    A = 32'h1234_5678; B = 32'h1234_5678;
    #1;
    chk("cmp_equal", 32'(Equal), 1);
    chk("cmp_eq_greater", 32'(Greater), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
